mult_div_unit: RTL

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Consumes the two register-file read operands and implements MIPS MULT/MULTU/DIV/DIVU into dedicated HI/LO registers.
- HI/LO outputs feed the writeback select for MFHI/MFLO.
- Uses start/busy/done handshake so the control FSM can stall while an operation runs.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  localparam int          MDU_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's-complement negation of the input when i_neg is set, otherwise pass-through.
module cond_negate #(
  parameter int N = 32
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_y
);

  assign o_y = i_neg ? (~i_a + N'(1)) : i_a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | one shift-add or restoring-divide step per cycle
// FIX   | sign correction and HI/LO writeback, done pulsed next cycle
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nxt;
  logic               w_busy;

  logic               r_is_div;
  logic               r_s0;
  logic               r_s1;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_in0_raw;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div0;

  logic               w_start;
  logic               w_in_div;
  logic               w_in_s0;
  logic               w_in_s1;
  logic [WIDTH-1:0]   w_mag0;
  logic [WIDTH-1:0]   w_mag1;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_div_nxt;

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_start  = (r_state == IDLE) && start;
  assign w_in_div = op_is_div(op);
  assign w_in_s0  = op_is_signed(op) & in0[WIDTH-1];
  assign w_in_s1  = op_is_signed(op) & in1[WIDTH-1];

  cond_negate #(.N(WIDTH)) u_neg_in0 (.i_neg(w_in_s0), .i_a(in0), .o_y(w_mag0));
  cond_negate #(.N(WIDTH)) u_neg_in1 (.i_neg(w_in_s1), .i_a(in1), .o_y(w_mag1));

  // Multiply: r_acc = {partial product, remaining multiplier bits}, r_opnd = multiplicand.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient}, r_opnd = divisor.
  // The trial difference MSB is the borrow because remainder < divisor always.
  assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial   = w_shift - {1'b0, r_opnd};
  assign w_borrow  = w_trial[WIDTH];
  assign w_div_nxt = {(w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], ~w_borrow};

  cond_negate #(.N(2*WIDTH)) u_neg_prod (
    .i_neg(r_s0 ^ r_s1), .i_a(r_acc), .o_y(w_prod_fix)
  );
  cond_negate #(.N(WIDTH)) u_neg_quot (
    .i_neg(r_s0 ^ r_s1), .i_a(r_acc[WIDTH-1:0]), .o_y(w_quot_fix)
  );
  cond_negate #(.N(WIDTH)) u_neg_rem (
    .i_neg(r_s0), .i_a(r_acc[2*WIDTH-1:WIDTH]), .o_y(w_rem_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == CW'(ITER - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state != IDLE) w_busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div  <= 1'b0;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_dbz     <= 1'b0;
      r_in0_raw <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (w_start) begin
            r_is_div  <= w_in_div;
            r_s0      <= w_in_s0;
            r_s1      <= w_in_s1;
            r_dbz     <= w_in_div && (in1 == '0);
            r_in0_raw <= in0;
            r_opnd    <= w_in_div ? w_mag1 : w_mag0;
            r_acc     <= {{WIDTH{1'b0}}, (w_in_div ? w_mag0 : w_mag1)};
            r_cnt     <= '0;
            r_div0    <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_dbz) begin
            r_lo   <= DIV0_QUOT;
            r_hi   <= r_in0_raw;
            r_div0 <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= w_quot_fix;
            r_hi <= w_rem_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign div_by_zero = r_div0;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
